// File: rtl/shift_unit_pipe.sv
// shift_unit_pipe
//   Pipelined shift / bit-manipulation unit for the ALU execute stage.
//   Operations (in_func): 100 SL, 000 SRL, 001 SRA, 010 LUI, 011 HAM (popcount),
//   101 ROL, 110 ROR, 111 CLZ. Every operation has a latency of STAGES cycles
//   when the output is not stalled, and results leave in accept order.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready = !out_valid || out_ready)
//   in_x, in_y            data operand, shift amount / LUI immediate
//   in_func, in_tag       operation select, sideband tag carried to out_tag
//   out_valid / out_ready result handshake
//   out_c, out_tag        result and tag of the operation that produced it
//
// The log2 network (barrel shifter, SWAR popcount tree, CLZ binary search) has
// SHAMT_W levels. They are dealt out over the STAGES register slots as evenly
// as possible, so a slot may hold zero levels when STAGES > SHAMT_W.
module shift_unit_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STAGES  = 2,
    parameter int TAG_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_x,
    input  logic [WIDTH-1:0]  in_y,
    input  logic [2:0]        in_func,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_c,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int CNT_W = SHAMT_W + 1;

    localparam logic [2:0] F_SRL = 3'b000;
    localparam logic [2:0] F_SRA = 3'b001;
    localparam logic [2:0] F_LUI = 3'b010;
    localparam logic [2:0] F_HAM = 3'b011;
    localparam logic [2:0] F_SL  = 3'b100;
    localparam logic [2:0] F_ROL = 3'b101;
    localparam logic [2:0] F_ROR = 3'b110;
    localparam logic [2:0] F_CLZ = 3'b111;

    // val is the working word: shifted data, partial popcount fields, or the
    // CLZ-normalised operand. cnt accumulates the CLZ count.
    typedef struct packed {
        logic               valid;
        logic [2:0]         func;
        logic [TAG_W-1:0]   tag;
        logic [SHAMT_W-1:0] sh;
        logic [CNT_W-1:0]   cnt;
        logic [WIDTH-1:0]   val;
    } stage_t;

    // Popcount level j: mask selecting the low half of each 2^(j+1)-bit field.
    function automatic logic [WIDTH-1:0] ham_mask(input int j);
        logic [WIDTH-1:0] m;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = (((i >> j) % 2) == 0);
        end
        return m;
    endfunction

    // Apply network levels lo..hi-1. Shifts and popcount walk levels from the
    // smallest distance up; CLZ walks them from the largest distance down.
    function automatic stage_t run_levels(input stage_t st, input int lo, input int hi);
        stage_t           r;
        int               a;
        logic [WIDTH-1:0] top;
        r = st;
        for (int j = 0; j < SHAMT_W; j++) begin
            if (j >= lo && j < hi) begin
                a = 1 << j;
                case (r.func)
                    F_SL:  if (r.sh[j]) r.val = r.val << a;
                    F_SRL: if (r.sh[j]) r.val = r.val >> a;
                    F_SRA: if (r.sh[j]) r.val = $signed(r.val) >>> a;
                    F_ROL: if (r.sh[j]) r.val = (r.val << a) | (r.val >> (WIDTH - a));
                    F_ROR: if (r.sh[j]) r.val = (r.val >> a) | (r.val << (WIDTH - a));
                    F_HAM: r.val = (r.val & ham_mask(j)) + ((r.val >> a) & ham_mask(j));
                    F_CLZ: begin
                        a   = 1 << (SHAMT_W - 1 - j);
                        top = ~({WIDTH{1'b1}} >> a);
                        if ((r.val & top) == '0) begin
                            r.cnt = r.cnt + CNT_W'(a);
                            r.val = r.val << a;
                        end
                    end
                    default: ;
                endcase
            end
        end
        return r;
    endfunction

    // After the binary search the MSB is set unless the operand was zero, in
    // which case the count is one short of WIDTH.
    function automatic logic [WIDTH-1:0] finalize_val(input stage_t st);
        logic [WIDTH-1:0] r;
        r = st.val;
        if (st.func == F_CLZ) begin
            r = WIDTH'(st.cnt + CNT_W'(!st.val[WIDTH-1]));
        end
        return r;
    endfunction

    logic   adv;
    stage_t entry;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        entry       = '0;
        entry.valid = in_valid;
        entry.func  = in_func;
        entry.tag   = in_tag;
        entry.sh    = in_y[SHAMT_W-1:0];
        entry.val   = (in_func == F_LUI) ? (in_y << (WIDTH / 2)) : in_x;
    end

    // Intermediate slots. Data only loads with a valid op, so bubbles leave the
    // previous contents in place and the output stays 0 until the first result.
    for (genvar s = 0; s < STAGES - 1; s++) begin : g_mid
        localparam int LO = (s * SHAMT_W) / STAGES;
        localparam int HI = ((s + 1) * SHAMT_W) / STAGES;
        stage_t src;
        stage_t q;

        if (s == 0) begin : g_from_entry
            assign src = entry;
        end else begin : g_from_prev
            assign src = g_mid[s-1].q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (adv) begin
                if (src.valid) q <= run_levels(src, LO, HI);
                else           q.valid <= 1'b0;
            end
        end
    end

    // Final slot holds only what leaves the unit.
    localparam int LAST_LO = ((STAGES - 1) * SHAMT_W) / STAGES;
    stage_t last_src;

    if (STAGES == 1) begin : g_last_direct
        assign last_src = entry;
    end else begin : g_last_pipe
        assign last_src = g_mid[STAGES-2].q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_c     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            out_valid <= last_src.valid;
            if (last_src.valid) begin
                out_c   <= finalize_val(run_levels(last_src, LAST_LO, SHAMT_W));
                out_tag <= last_src.tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
module tb_shift_unit_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_x;
    logic [WIDTH-1:0]  in_y;
    logic [2:0]        in_func;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_c;
    logic [TAG_W-1:0]  out_tag;

    shift_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_func(in_func), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    bit          lat_chk = 1'b0;
    bit          last_acc;
    logic        last_in_ready;
    logic [31:0] last_c;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_c;
    logic [4:0]  prev_tag;

    // Reference: results straight from the operation definitions.
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        int          sh;
        int          n;
        logic [63:0] xx;
        logic [31:0] r;
        sh = int'(y % 32);
        xx = {x, x};
        r  = '0;
        case (f)
            3'b100: r = x << sh;
            3'b000: r = x >> sh;
            3'b001: begin
                r = x >> sh;
                if (x[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'b010: r = {y[15:0], 16'h0000};
            3'b011: begin
                n = 0;
                for (int i = 0; i < 32; i++) n += int'(x[i]);
                r = 32'(n);
            end
            3'b101: begin xx = xx << sh; r = xx[63:32]; end
            3'b110: begin xx = xx >> sh; r = xx[31:0]; end
            default: begin
                n = 0;
                while (n < 32 && x[31-n] == 1'b0) n++;
                r = 32'(n);
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] t);
        in_valid = v;
        in_func  = f;
        in_x     = x;
        in_y     = y;
        in_tag   = t;
    endtask

    // One clock: sample at negedge, update scoreboard, return 1 after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        last_acc      = 1'b0;
        last_in_ready = in_ready;
        if (!rst) begin
            chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                chk("stall_hold_c", out_c, prev_c);
                chk("stall_hold_tag", 32'(out_tag), 32'(prev_tag));
            end
            if (out_valid && out_ready) begin
                chk("result_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_c", out_c, e.c);
                    chk("out_tag", 32'(out_tag), 32'(e.tag));
                    if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'(STAGES));
                end
                pops++;
                last_c = out_c;
            end
            if (in_valid && in_ready) begin
                e.c   = ref_op(in_func, in_x, in_y);
                e.tag = in_tag;
                e.acc = cyc;
                sb.push_back(e);
                last_acc = 1'b1;
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_c     = out_c;
        prev_tag   = out_tag;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic one_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp);
        int p;
        drive(1'b1, f, x, y, 5'(cyc));
        tick();
        drive(1'b0, 3'b000, '0, '0, '0);
        p = pops;
        tick();
        tick();
        chk({name, "_arrived"}, 32'(pops - p), 32'd1);
        chk(name, last_c, exp);
    endtask

    function automatic logic [31:0] rand_x();
        if ($urandom_range(0, 3) == 0) return 32'd1 << $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) return '0;
        return $urandom;
    endfunction

    initial begin
        logic [2:0]  sf[4];
        logic [31:0] sx[4];
        logic [31:0] sy[4];
        int          idx;
        int          p;

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 5'd7);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 3'b000, '0, '0, '0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_c", out_c, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed values, single ops, unstalled.
        lat_chk = 1'b1;
        one_op("sra",     3'b001, 32'h8000_0000, 32'd4,          32'hF800_0000);
        one_op("srl",     3'b000, 32'h8000_0000, 32'd4,          32'h0800_0000);
        one_op("sl",      3'b100, 32'h0000_0001, 32'd31,         32'h8000_0000);
        one_op("ror_33",  3'b110, 32'h0000_0001, 32'd33,         32'h8000_0000);
        one_op("rol",     3'b101, 32'h8000_0001, 32'd4,          32'h0000_0018);
        one_op("ham",     3'b011, 32'hF0F0_F0F0, 32'd0,          32'd16);
        one_op("clz_0",   3'b111, 32'h0000_0000, 32'd0,          32'd32);
        one_op("clz_16",  3'b111, 32'h0001_0000, 32'd0,          32'd15);
        one_op("clz_all", 3'b111, 32'hFFFF_FFFF, 32'd0,          32'd0);
        one_op("lui",     3'b010, 32'h1111_1111, 32'hABCD_1234,  32'h1234_0000);
        one_op("sra_pos", 3'b001, 32'h7000_0000, 32'hFFFF_FFE4,  32'h0700_0000);
        one_op("ham_all", 3'b011, 32'hFFFF_FFFF, 32'd5,          32'd32);

        // Back-to-back stream, exact latency and no gaps.
        p = pops;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), rand_x(), $urandom, 5'(i));
            tick();
        end
        drive(1'b0, 3'b000, '0, '0, '0);
        for (int i = 0; i < STAGES + 2; i++) tick();
        chk("stream_count", 32'(pops - p), 32'd10);

        // Output stalled: pipeline fills, in_ready drops, release drains in order.
        for (int i = 0; i < 4; i++) begin
            sf[i] = 3'($urandom_range(0, 7));
            sx[i] = rand_x();
            sy[i] = $urandom;
        end
        out_ready = 1'b0;
        p   = pops;
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, sf[idx], sx[idx], sy[idx], 5'(20 + idx));
            tick();
            if (last_acc) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'(STAGES));
        chk("stall_in_ready", 32'(last_in_ready), 32'd0);
        chk("stall_no_output", 32'(pops - p), 32'd0);
        out_ready = 1'b1;
        lat_chk   = 1'b0;
        for (int k = 0; k < 20 && idx < 4; k++) begin
            drive(1'b1, sf[idx], sx[idx], sy[idx], 5'(20 + idx));
            tick();
            if (last_acc) idx++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd4);
        drive(1'b0, 3'b000, '0, '0, '0);
        for (int i = 0; i < STAGES + 3; i++) tick();
        chk("stall_results", 32'(pops - p), 32'd4);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rand_x(), $urandom, 5'($urandom));
            tick();
        end
        drive(1'b0, 3'b000, '0, '0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        chk("random_drained", 32'(sb.size()), 32'd0);

        // Reset with ops in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b011, $urandom, '0, 5'(10 + i));
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 3'b100, 32'h0000_0001, 32'd3, 5'd31);
        tick();
        rst = 1'b0;
        sb.delete();
        drive(1'b0, 3'b000, '0, '0, '0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_c", out_c, 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        p = pops;
        for (int i = 0; i < 6; i++) tick();
        chk("midrst_no_stale", 32'(pops - p), 32'd0);

        one_op("post_rst_rol", 3'b101, 32'h1234_5678, 32'd8, 32'h3456_7812);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
